id_stage: RTL and testbench

Pipelined instruction-decode stage for the 16-bit CPU, the successor to the single-cycle decode/register-file wrapper. It decodes one instruction per cycle, reads a 16-entry register file through two read ports with an optional write-back bypass, and registers all results into an ID/EX pipeline register. It also detects load-use hazards and handles flush, downstream stall and sticky halt. It sits between the fetch stage (IF/ID register) and the execute stage.

---
 rtl/id_stage.sv | 219 +++++++++++++++++++++
 tb/tb_id_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Pipelined instruction decode: register file, hazard/halt control, ID/EX register.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle write-back data onto the read ports.
module id_stage #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic              instr_vld,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic              wb_we,
    input  logic [3:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_out,
    output logic              ex_vld,
    output logic [DATA_W-1:0] ex_p0,
    output logic [DATA_W-1:0] ex_p1,
    output logic [DATA_W-1:0] ex_imm,
    output logic [2:0]        ex_aluOp,
    output logic [3:0]        ex_shAmt,
    output logic              ex_src1sel,
    output logic [3:0]        ex_dst,
    output logic              ex_we,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic              ex_hlt
);

    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] p0;
        logic [DATA_W-1:0] p1;
        logic [DATA_W-1:0] imm;
        logic [2:0]        alu_op;
        logic [3:0]        sh_amt;
        logic              src1sel;
        logic [3:0]        dst;
        logic              we;
        logic              mem_rd;
        logic              mem_wr;
        logic              hlt;
    } idex_t;

    logic [DATA_W-1:0] regs_r [16];
    idex_t             idex_r;
    idex_t             dec_s;
    logic              halted_r;

    logic [3:0]        op_s, rd_s, rs_s, rt_s;
    logic [3:0]        rd_b_addr_s;
    logic [DATA_W-1:0] rd_a_data_s, rd_b_data_s;
    logic              use_a_s, use_b_s;
    logic              hazard_s;
    logic              load_s;

    assign op_s = instr[15:12];
    assign rd_s = instr[11:8];
    assign rs_s = instr[7:4];
    assign rt_s = instr[3:0];

    // Stores read the data register (rd) on port B; everything else reads rt.
    always_comb begin
        rd_b_addr_s = rt_s;
        if (op_s == OP_SW) begin
            rd_b_addr_s = rd_s;
        end else begin
            rd_b_addr_s = rt_s;
        end
    end

    // Register file read ports; R0 is hard-wired to zero.
    always_comb begin
        rd_a_data_s = regs_r[rs_s];
        rd_b_data_s = regs_r[rd_b_addr_s];
`ifdef ID_WB_BYPASS_EN
        if (wb_we && (wb_addr == rs_s)) begin
            rd_a_data_s = wb_data;
        end else begin
            rd_a_data_s = regs_r[rs_s];
        end
        if (wb_we && (wb_addr == rd_b_addr_s)) begin
            rd_b_data_s = wb_data;
        end else begin
            rd_b_data_s = regs_r[rd_b_addr_s];
        end
`endif
        if (rs_s == 4'd0) begin
            rd_a_data_s = '0;
        end else begin
            rd_a_data_s = rd_a_data_s;
        end
        if (rd_b_addr_s == 4'd0) begin
            rd_b_data_s = '0;
        end else begin
            rd_b_data_s = rd_b_data_s;
        end
    end

    // Instruction decode into the next ID/EX contents plus read-port usage.
    always_comb begin
        dec_s   = '0;
        use_a_s = 1'b0;
        use_b_s = 1'b0;
        if (instr_vld) begin
            case (op_s)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
                    dec_s.vld    = 1'b1;
                    dec_s.alu_op = op_s[2:0];
                    dec_s.p0     = rd_a_data_s;
                    dec_s.p1     = rd_b_data_s;
                    dec_s.we     = 1'b1;
                    dec_s.dst    = rd_s;
                    use_a_s      = 1'b1;
                    use_b_s      = 1'b1;
                end
                4'h5, 4'h6, 4'h7: begin
                    dec_s.vld     = 1'b1;
                    dec_s.alu_op  = op_s[2:0];
                    dec_s.p0      = rd_a_data_s;
                    dec_s.sh_amt  = rt_s;
                    dec_s.src1sel = 1'b1;
                    dec_s.we      = 1'b1;
                    dec_s.dst     = rd_s;
                    use_a_s       = 1'b1;
                end
                OP_LW: begin
                    dec_s.vld     = 1'b1;
                    dec_s.p0      = rd_a_data_s;
                    dec_s.imm     = {{(DATA_W-4){rt_s[3]}}, rt_s};
                    dec_s.src1sel = 1'b1;
                    dec_s.we      = 1'b1;
                    dec_s.mem_rd  = 1'b1;
                    dec_s.dst     = rd_s;
                    use_a_s       = 1'b1;
                end
                OP_SW: begin
                    dec_s.vld     = 1'b1;
                    dec_s.p0      = rd_a_data_s;
                    dec_s.p1      = rd_b_data_s;
                    dec_s.imm     = {{(DATA_W-4){rt_s[3]}}, rt_s};
                    dec_s.src1sel = 1'b1;
                    dec_s.mem_wr  = 1'b1;
                    use_a_s       = 1'b1;
                    use_b_s       = 1'b1;
                end
                OP_HLT: begin
                    dec_s.vld = 1'b1;
                    dec_s.hlt = 1'b1;
                end
                default: begin
                    dec_s = '0;
                end
            endcase
        end else begin
            dec_s = '0;
        end
    end

    assign hazard_s = instr_vld && idex_r.vld && idex_r.mem_rd && (idex_r.dst != 4'd0) &&
                      ((use_a_s && (rs_s == idex_r.dst)) || (use_b_s && (rd_b_addr_s == idex_r.dst)));
    assign load_s    = !ex_stall && !flush && !hazard_s && !halted_r;
    assign stall_out = ex_stall | hazard_s | halted_r;

    // Register file write port; runs regardless of pipeline stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wb_we && (wb_addr != 4'd0)) begin
            regs_r[wb_addr] <= wb_data;
        end else begin
            regs_r <= regs_r;
        end
    end

    // ID/EX pipeline register with stall > flush > hazard/halt > load priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_r <= '0;
        end else if (ex_stall) begin
            idex_r <= idex_r;
        end else if (flush || hazard_s || halted_r) begin
            idex_r <= '0;
        end else begin
            idex_r <= dec_s;
        end
    end

    // Sticky halt: set only when a HLT actually lands in ID/EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_r <= 1'b0;
        end else if (load_s && dec_s.hlt) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    assign ex_vld     = idex_r.vld;
    assign ex_p0      = idex_r.p0;
    assign ex_p1      = idex_r.p1;
    assign ex_imm     = idex_r.imm;
    assign ex_aluOp   = idex_r.alu_op;
    assign ex_shAmt   = idex_r.sh_amt;
    assign ex_src1sel = idex_r.src1sel;
    assign ex_dst     = idex_r.dst;
    assign ex_we      = idex_r.we;
    assign ex_mem_rd  = idex_r.mem_rd;
    assign ex_mem_wr  = idex_r.mem_wr;
    assign ex_hlt     = idex_r.hlt;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a behavioural model predicts every ID/EX update and stall_out.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'h0;
    logic        instr_vld = 1'b0;
    logic        flush = 1'b0;
    logic        ex_stall = 1'b0;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_addr = 4'h0;
    logic [15:0] wb_data = 16'h0;
    logic        stall_out, ex_vld, ex_src1sel, ex_we, ex_mem_rd, ex_mem_wr, ex_hlt;
    logic [15:0] ex_p0, ex_p1, ex_imm;
    logic [2:0]  ex_aluOp;
    logic [3:0]  ex_shAmt, ex_dst;

    id_stage #(.DATA_W(16)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_vld(instr_vld), .flush(flush),
        .ex_stall(ex_stall), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_out(stall_out), .ex_vld(ex_vld), .ex_p0(ex_p0), .ex_p1(ex_p1), .ex_imm(ex_imm),
        .ex_aluOp(ex_aluOp), .ex_shAmt(ex_shAmt), .ex_src1sel(ex_src1sel), .ex_dst(ex_dst),
        .ex_we(ex_we), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_hlt(ex_hlt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic [15:0] p0, p1, imm;
        logic [2:0]  alu;
        logic [3:0]  sh;
        logic        src1;
        logic [3:0]  dst;
        logic        we, mrd, mwr, hlt;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    logic [15:0] mregs [16];
    exp_t        m_ex;
    logic        m_halted;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] rdval(input logic [3:0] a);
        if (a == 4'd0) return 16'h0;
`ifdef ID_WB_BYPASS_EN
        if (wb_we && wb_addr == a) return wb_data;
`endif
        return mregs[a];
    endfunction

    // Does the instruction consume register r through one of its source operands?
    function automatic logic reads_reg(input logic [15:0] ins, input logic [3:0] r);
        int op = int'(ins[15:12]);
        if (op <= 4)  return (ins[7:4] == r) || (ins[3:0] == r);
        if (op <= 8)  return ins[7:4] == r;
        if (op == 9)  return (ins[7:4] == r) || (ins[11:8] == r);
        return 1'b0;
    endfunction

    function automatic exp_t decode_m(input logic [15:0] ins, input logic v);
        exp_t e = '0;
        int   op = int'(ins[15:12]);
        logic [15:0] sx = {{12{ins[3]}}, ins[3:0]};
        if (!v) return e;
        if (op <= 4) begin
            e.vld = 1; e.alu = ins[14:12]; e.p0 = rdval(ins[7:4]); e.p1 = rdval(ins[3:0]);
            e.we = 1; e.dst = ins[11:8];
        end else if (op <= 7) begin
            e.vld = 1; e.alu = ins[14:12]; e.p0 = rdval(ins[7:4]); e.sh = ins[3:0];
            e.src1 = 1; e.we = 1; e.dst = ins[11:8];
        end else if (op == 8) begin
            e.vld = 1; e.p0 = rdval(ins[7:4]); e.imm = sx; e.src1 = 1; e.we = 1;
            e.mrd = 1; e.dst = ins[11:8];
        end else if (op == 9) begin
            e.vld = 1; e.p0 = rdval(ins[7:4]); e.p1 = rdval(ins[11:8]); e.imm = sx;
            e.src1 = 1; e.mwr = 1;
        end else if (op == 15) begin
            e.vld = 1; e.hlt = 1;
        end
        return e;
    endfunction

    // Drive one cycle of inputs, check stall_out, and queue the predicted ID/EX result.
    task automatic step(input logic r, input logic [15:0] ins, input logic v, input logic fl,
                        input logic st, input logic we, input logic [3:0] wa, input logic [15:0] wd);
        logic haz;
        exp_t nx;
        @(negedge clk);
        rst = r; instr = ins; instr_vld = v; flush = fl; ex_stall = st;
        wb_we = we; wb_addr = wa; wb_data = wd;
        #1;
        haz = v && m_ex.vld && m_ex.mrd && (m_ex.dst != 4'd0) && reads_reg(ins, m_ex.dst);
        chk("stall_out", {31'd0, stall_out}, {31'd0, st | haz | m_halted});
        nx = m_ex;
        if (r)                          nx = '0;
        else if (st)                    nx = m_ex;
        else if (fl || haz || m_halted) nx = '0;
        else                            nx = decode_m(ins, v);
        if (r) m_halted = 1'b0;
        else if (!st && !fl && !haz && !m_halted && nx.hlt) m_halted = 1'b1;
        if (r) begin
            for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
        end else if (we && wa != 4'd0) begin
            mregs[wa] = wd;
        end
        m_ex = nx;
        sb_q.push_back(nx);
    endtask

    task automatic idle(input logic [15:0] ins, input logic v);
        step(1'b0, ins, v, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    endtask

    task automatic after_edge;
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare the full ID/EX record after every edge that has a prediction.
    always @(posedge clk) begin
        exp_t e, a;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            a = {ex_vld, ex_p0, ex_p1, ex_imm, ex_aluOp, ex_shAmt, ex_src1sel, ex_dst,
                 ex_we, ex_mem_rd, ex_mem_wr, ex_hlt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL idex actual=%h expected=%h", a, e);
            end
        end
    end

    initial begin
        logic [15:0] bypass_exp;
        logic [15:0] rin;
        logic [3:0]  op;
        for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
        m_ex = '0;
        m_halted = 1'b0;

        step(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
        step(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
        after_edge();
        chk("reset_vld", {31'd0, ex_vld}, 32'd0);
        chk("reset_p0", {16'd0, ex_p0}, 32'd0);

        // Write R3 then ADD R1,R3,R3
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 16'h1234);
        idle(16'h0133, 1'b1);
        after_edge();
        chk("add_p0", {16'd0, ex_p0}, 32'h1234);
        chk("add_p1", {16'd0, ex_p1}, 32'h1234);
        chk("add_we_dst", {27'd0, ex_we, ex_dst}, {27'd0, 1'b1, 4'd1});
        chk("add_aluop", {29'd0, ex_aluOp}, 32'd0);

        // Same-cycle write-back of R5 with ADD R2,R5,R0
        step(1'b0, 16'h0250, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 16'hBEEF);
        after_edge();
`ifdef ID_WB_BYPASS_EN
        bypass_exp = 16'hBEEF;
`else
        bypass_exp = 16'h0000;
`endif
        chk("bypass_p0", {16'd0, ex_p0}, {16'd0, bypass_exp});
        chk("bypass_p1", {16'd0, ex_p1}, 32'd0);

        // R0 stays zero
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'hFFFF);
        idle(16'h0700, 1'b1);
        after_edge();
        chk("r0_zero", {16'd0, ex_p0}, 32'd0);

        // Load-use: LW R4,(R2+0xF) then ADD R6,R4,R1
        idle(16'h842F, 1'b1);
        after_edge();
        chk("lw_imm", {16'd0, ex_imm}, 32'hFFFF);
        chk("lw_mrd", {31'd0, ex_mem_rd}, 32'd1);
        idle(16'h0641, 1'b1);
        chk("lu_stall", {31'd0, stall_out}, 32'd1);
        after_edge();
        chk("lu_bubble", {31'd0, ex_vld}, 32'd0);
        idle(16'h0641, 1'b1);
        chk("lu_release", {31'd0, stall_out}, 32'd0);
        after_edge();
        chk("lu_issue", {27'd0, ex_vld, ex_dst}, {27'd0, 1'b1, 4'd6});

        // SW in ID/EX held by ex_stall; flush squashes the instruction in ID
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 16'h00AA);
        idle(16'h9123, 1'b1);
        step(1'b0, 16'h0811, 1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 16'h5A5A);
        after_edge();
        chk("stall_mwr0", {31'd0, ex_mem_wr}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0);
            after_edge();
            chk("stall_mwr", {31'd0, ex_mem_wr}, 32'd1);
        end
        idle(16'h0, 1'b0);
        after_edge();
        chk("flush_gone", {31'd0, ex_vld}, 32'd0);
        idle(16'h0A90, 1'b1);
        after_edge();
        chk("wb_in_stall", {16'd0, ex_p0}, 32'h5A5A);

        // flush with HLT in ID: no halt
        step(1'b0, 16'hF000, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0);
        after_edge();
        chk("flush_hlt", {30'd0, ex_hlt, stall_out}, 32'd0);

        // HLT then ADDs
        idle(16'hF000, 1'b1);
        after_edge();
        chk("hlt_set", {31'd0, ex_hlt}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            idle(16'h0133, 1'b1);
            chk("halt_stall", {31'd0, stall_out}, 32'd1);
            after_edge();
            chk("halt_bubble", {31'd0, ex_vld}, 32'd0);
        end
        step(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
        after_edge();
        chk("halt_cleared", {31'd0, stall_out}, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h8;
            rin = {op, 1'b0, 3'($urandom_range(0, 7)), 1'b0, 3'($urandom_range(0, 7)),
                   4'($urandom_range(0, 15))};
            step($urandom_range(0, 59) == 0, rin, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)), 16'($urandom));
        end
        idle(16'h0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        chk("sb_drain", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
